// File: rtl/wisc_fetch_unit.sv
// WISC instruction-fetch front end: registered fetch PC, single-outstanding imem handshake,
// prefetch FIFO drained by decode, taken-branch redirect with response squashing, sticky halt.
module wisc_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned FQ_DEPTH = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_next,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               hlt
);

    localparam int unsigned PtrW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);
    localparam logic [CntW:0] DepthVal = (CntW + 1)'(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] EvenMask = {{(ADDR_W - 1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0]  fpc, fpcNext;
    logic [ADDR_W-1:0]  tagPc, tagPcNext;
    logic [CntW-1:0]    count, countNext;
    logic [PtrW-1:0]    rdPtr, rdPtrNext, wrPtr, wrPtrNext;
    logic               outstanding, outstandingNext;
    logic               squash, squashNext;
    logic               halted, haltedNext;
    logic [ADDR_W-1:0]  qPc [FQ_DEPTH];
    logic [INSTR_W-1:0] qInstr [FQ_DEPTH];
    logic               accept, rsp, push, pop;
    logic [CntW:0]      occupancy;

    // A granted request always owns a queue slot, so a response can never overflow.
    always_comb begin
        occupancy     = {1'b0, count} + {{CntW{1'b0}}, outstanding};
        imem_req      = rst_n && !halted && !halt && !redirect &&
                        (!outstanding || imem_rvalid) && (occupancy < DepthVal);
        imem_addr     = rst_n ? fpc : '0;
        instr_valid   = (count != '0) && !halted;
        instr         = '0;
        instr_pc      = '0;
        instr_pc_next = '0;
        if (instr_valid) begin
            instr         = qInstr[rdPtr];
            instr_pc      = qPc[rdPtr];
            instr_pc_next = qPc[rdPtr] + ADDR_W'(2);
        end
        hlt = halted;
    end

    always_comb begin
        fpcNext         = fpc;
        tagPcNext       = tagPc;
        countNext       = count;
        rdPtrNext       = rdPtr;
        wrPtrNext       = wrPtr;
        outstandingNext = outstanding;
        squashNext      = squash;
        haltedNext      = halted;
        accept          = imem_req && imem_gnt;
        rsp             = outstanding && imem_rvalid;
        pop             = instr_valid && instr_ready;
        push            = 1'b0;
        if (halt || redirect) begin
            countNext       = '0;
            rdPtrNext       = '0;
            wrPtrNext       = '0;
            // The in-flight word belongs to the abandoned path; drop it when it lands.
            outstandingNext = outstanding && !imem_rvalid;
            squashNext      = outstanding && !imem_rvalid;
            if (halt) begin
                haltedNext = 1'b1;
            end else begin
                fpcNext = redirect_pc & EvenMask;
            end
        end else begin
            if (accept) begin
                fpcNext         = fpc + ADDR_W'(2);
                tagPcNext       = fpc;
                outstandingNext = 1'b1;
            end else if (rsp) begin
                outstandingNext = 1'b0;
            end
            if (rsp) begin
                if (squash) begin
                    squashNext = 1'b0;
                end else begin
                    push = !halted;
                end
            end
            if (push) begin
                wrPtrNext = wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtrNext = rdPtr + PtrW'(1);
            end
            if (push && !pop) begin
                countNext = count + CntW'(1);
            end else if (!push && pop) begin
                countNext = count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc         <= ResetPc;
            tagPc       <= '0;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            outstanding <= 1'b0;
            squash      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            fpc         <= fpcNext;
            tagPc       <= tagPcNext;
            count       <= countNext;
            rdPtr       <= rdPtrNext;
            wrPtr       <= wrPtrNext;
            outstanding <= outstandingNext;
            squash      <= squashNext;
            halted      <= haltedNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            qPc[wrPtr]    <= tagPc;
            qInstr[wrPtr] <= imem_rdata;
        end
    end

endmodule
